commit_trace_tx: RTL and testbench
==================================

Name: commit_trace_tx

Overview:
Synthesizable producer end of the commit/writeback co-simulation protocol. It captures per-cycle retirement events from a Rocket-style pipeline and FPU: instruction commit, integer writeback, FP writeback and trap. Events are serialized into an ordered record stream over a valid/ready interface, which the checker side consumes one record at a time. Records are buffered in a multi-write-port circular FIFO so checker backpressure never stalls the core; overload is flagged, never hidden.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4.
SEQ_W, 16, width of the record sequence number.

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
commit_valid  in  1  instruction retired this cycle
commit_pc  in  64  retired PC, sign-extended
commit_insn  in  32  retired instruction bits
int_wb_valid  in  1  integer RF write (normal or long-latency, pre-merged)
int_wb_addr  in  5  integer destination register
int_wb_data  in  64  integer write data
fp_wb_valid  in  1  FP RF write (arith or load, pre-merged)
fp_wb_addr  in  5  FP destination register
fp_wb_data  in  64  FP write data (raw 64-bit container)
trap_valid  in  1  interrupt/exception raised
trap_cause  in  64  cause value
clr_overflow  in  1  single-cycle pulse; clears overflow and drop_count
out_valid  out  1  record available
out_ready  in  1  consumer accepts record
out_kind  out  2  0=commit, 1=int wb, 2=fp wb, 3=trap
out_addr  out  5  register address (0 for commit/trap)
out_data  out  64  pc / wdata / cause by kind
out_insn  out  32  insn for commit, else 0
out_seq  out  SEQ_W  record sequence number
level  out  log2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: at least one cycle's events dropped
drop_count  out  16  number of dropped cycles, saturating at 0xFFFF

Behaviour:
- Reset (reset low, async): rd/wr pointers, level, out_seq counter, overflow, drop_count = 0; out_valid = 0. Payload outputs = 0. Reset mid-stream discards all queued records.
- Per cycle, n = commit_valid + int_wb_valid + fp_wb_valid + trap_valid (0..4).
- Fixed intra-cycle order: commit, int wb, fp wb, trap. Records are written to consecutive slots from wr_ptr in this order. Absent events are skipped without gaps.
- Admission is all-or-nothing. Accept iff DEPTH - level >= n, with level taken at the start of the cycle; a dequeue in the same cycle does not free space for this cycle. On reject: no records written; overflow <= 1; drop_count += 1 (saturating); seq not advanced.
- Each accepted record receives seq = counter + index in the cycle's order; the counter advances by n. Wrap is modulo 2^SEQ_W.
- Latency: an event sampled at posedge N is visible on out_* after posedge N (registered FIFO, head read from storage). It is not visible in the same cycle.
- out_valid = (level != 0). Handshake fires when out_valid && out_ready. On fire, rd_ptr advances by 1.
- While out_valid && !out_ready, all out_* must remain stable.
- level_next = level + (accepted ? n : 0) - fire. Simultaneous enqueue and dequeue are legal. Pointers wrap modulo DEPTH.
- Unused fields are driven 0: out_addr for commit/trap, out_insn for non-commit.
- clr_overflow: overflow <= 0, drop_count <= 0. If a reject occurs in the same cycle, the reject wins: overflow = 1, drop_count = 1.
- No combinational path from commit/wb inputs to out_*. out_ready affects only the pointer update.

Test Plan:
- Single commit, pc=0x80000000, insn=0x00000013, out_ready=1 -> one cycle later out_valid=1, kind=0, data=0x80000000, insn=0x13, seq=0; level returns to 0 after fire.
- All four events in one cycle (int x5=0x1234, fp f3=0x3FF0000000000000, cause=0x8000000000000007) -> four records in order kind 0,1,2,3 with seq 0..3; addr 0,5,3,0.
- out_ready=0 for 10 cycles with 3 queued records -> out_* stable throughout; then out_ready=1 drains exactly 3 records in order.
- DEPTH=16, out_ready=0; fill to level=14, then present 4 events -> rejected: level stays 14, overflow=1, drop_count=1. Next cycle, 2 events -> accepted, level=16. Pulse clr_overflow -> overflow=0, drop_count=0.
- SEQ_W=4: issue 18 single commits with out_ready=1 -> out_seq goes 0..15, 0, 1.
- Assert reset low with 5 records queued and out_valid=1 -> out_valid drops immediately (async); after release, level=0, a new commit gets seq=0.

Source files
------------

// File: rtl/commit_trace_tx_if.sv
// Record stream from the trace producer to the checker: one record per
// valid/ready handshake.
interface commit_trace_tx_if #(
  parameter int SEQ_W = 16
);
  logic             valid;
  logic             ready;
  logic [1:0]       kind;
  logic [4:0]       addr;
  logic [63:0]      data;
  logic [31:0]      insn;
  logic [SEQ_W-1:0] seq;

  modport master (output valid, kind, addr, data, insn, seq, input ready);
  modport slave  (input valid, kind, addr, data, insn, seq, output ready);
endinterface

// File: rtl/commit_trace_tx.sv
// Producer end of the commit/writeback trace. Up to four retirement events
// per cycle (commit, int wb, fp wb, trap) are packed into consecutive FIFO
// slots in that fixed order. A cycle is admitted whole or dropped whole, so
// the core never stalls; drops are counted and flagged.
module commit_trace_tx #(
  parameter  int DEPTH = 16,
  parameter  int SEQ_W = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 commit_valid,
  input  logic [63:0]          commit_pc,
  input  logic [31:0]          commit_insn,
  input  logic                 int_wb_valid,
  input  logic [4:0]           int_wb_addr,
  input  logic [63:0]          int_wb_data,
  input  logic                 fp_wb_valid,
  input  logic [4:0]           fp_wb_addr,
  input  logic [63:0]          fp_wb_data,
  input  logic                 trap_valid,
  input  logic [63:0]          trap_cause,
  input  logic                 clr_overflow,
  commit_trace_tx_if.master    out,
  output logic [LW-1:0]        level,
  output logic                 overflow,
  output logic [15:0]          drop_count
);

  typedef struct packed {
    logic [1:0]       kind;
    logic [4:0]       addr;
    logic [63:0]      data;
    logic [31:0]      insn;
    logic [SEQ_W-1:0] seq;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [SEQ_W-1:0] seq_cnt;

  logic [3:0]       ev_v;
  logic [2:0]       off [4];
  logic [2:0]       n;
  rec_t             ev_rec [4];
  logic             accept;
  logic             fire;
  rec_t             head;

  // Slot offset of each event = number of present events ahead of it, so
  // absent events leave no gaps; seq follows the same offset.
  always_comb begin
    ev_v   = {trap_valid, fp_wb_valid, int_wb_valid, commit_valid};
    off[0] = 3'd0;
    off[1] = 3'(ev_v[0]);
    off[2] = 3'(ev_v[0]) + 3'(ev_v[1]);
    off[3] = 3'(ev_v[0]) + 3'(ev_v[1]) + 3'(ev_v[2]);
    n      = off[3] + 3'(ev_v[3]);

    ev_rec[0] = '{kind: 2'd0, addr: 5'd0, data: commit_pc,
                  insn: commit_insn, seq: seq_cnt + SEQ_W'(off[0])};
    ev_rec[1] = '{kind: 2'd1, addr: int_wb_addr, data: int_wb_data,
                  insn: 32'd0, seq: seq_cnt + SEQ_W'(off[1])};
    ev_rec[2] = '{kind: 2'd2, addr: fp_wb_addr, data: fp_wb_data,
                  insn: 32'd0, seq: seq_cnt + SEQ_W'(off[2])};
    ev_rec[3] = '{kind: 2'd3, addr: 5'd0, data: trap_cause,
                  insn: 32'd0, seq: seq_cnt + SEQ_W'(off[3])};

    // Space is judged on start-of-cycle level; a same-cycle pop doesn't count.
    accept = (LW'(DEPTH) - level) >= LW'(n);
    fire   = out.valid & out.ready;
  end

  // Multi-port write of the admitted events into consecutive slots.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (ev_v[i]) mem[wr_ptr + PW'(off[i])] <= ev_rec[i];
      end
    end
  end

  // Pointers, occupancy and sequence counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      seq_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr  <= wr_ptr + PW'(n);
        seq_cnt <= seq_cnt + SEQ_W'(n);
      end
      if (fire) rd_ptr <= rd_ptr + PW'(1);
      level <= level + (accept ? LW'(n) : LW'(0)) - LW'(fire);
    end
  end

  // Sticky overflow and saturating drop counter; a reject beats a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (!accept) begin
      overflow   <= 1'b1;
      if (clr_overflow)               drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Head is read straight from storage; payload forced to zero while empty
  // so reset and idle both present a clean all-zero record.
  always_comb begin
    head      = mem[rd_ptr];
    out.valid = (level != '0);
    out.kind  = out.valid ? head.kind : '0;
    out.addr  = out.valid ? head.addr : '0;
    out.data  = out.valid ? head.data : '0;
    out.insn  = out.valid ? head.insn : '0;
    out.seq   = out.valid ? head.seq  : '0;
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;
  localparam int DEPTH = 16;
  localparam int SEQ_W = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid, int_wb_valid, fp_wb_valid, trap_valid;
  logic [63:0] commit_pc, int_wb_data, fp_wb_data, trap_cause;
  logic [31:0] commit_insn;
  logic [4:0]  int_wb_addr, fp_wb_addr;
  logic        clr_overflow;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  commit_trace_tx_if #(.SEQ_W(SEQ_W)) out_if ();

  commit_trace_tx #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_insn(commit_insn),
    .int_wb_valid(int_wb_valid), .int_wb_addr(int_wb_addr), .int_wb_data(int_wb_data),
    .fp_wb_valid(fp_wb_valid), .fp_wb_addr(fp_wb_addr), .fp_wb_data(fp_wb_data),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .clr_overflow(clr_overflow), .out(out_if.master),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       kind;
    logic [4:0]       addr;
    logic [63:0]      data;
    logic [31:0]      insn;
    logic [SEQ_W-1:0] seq;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [SEQ_W-1:0] exp_seq;
  int               checks = 0;
  int               errors = 0;

  // Scoreboard monitor: sampled on the falling edge, the handshake seen here
  // is the one the DUT takes on the next rising edge.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      checks++;
      if (out_if.valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL out_valid: got %b want %b", out_if.valid, (sb.size() != 0));
      end
      if (out_if.valid === 1'b1 && out_if.ready === 1'b1 && sb.size() != 0) begin
        mon_e = sb.pop_front();
        checks++;
        if ({out_if.kind, out_if.addr, out_if.data, out_if.insn, out_if.seq} !==
            {mon_e.kind, mon_e.addr, mon_e.data, mon_e.insn, mon_e.seq}) begin
          errors++;
          $display("FAIL record: got k%0d a%0d d%h i%h s%0d want k%0d a%0d d%h i%h s%0d",
                   out_if.kind, out_if.addr, out_if.data, out_if.insn, out_if.seq,
                   mon_e.kind, mon_e.addr, mon_e.data, mon_e.insn, mon_e.seq);
        end
      end
    end
  end

  // Present one cycle of events; expectations are pushed only if the model
  // says the whole cycle fits.
  task automatic send(input bit c, input bit i, input bit f, input bit t,
                      input logic [63:0] pc, input logic [31:0] insn,
                      input logic [4:0] ia, input logic [63:0] id,
                      input logic [4:0] fa, input logic [63:0] fd,
                      input logic [63:0] cause);
    int   n;
    bit   acc;
    exp_t e;
    n   = int'(c) + int'(i) + int'(f) + int'(t);
    acc = (DEPTH - sb.size()) >= n;
    commit_valid = c; commit_pc = pc; commit_insn = insn;
    int_wb_valid = i; int_wb_addr = ia; int_wb_data = id;
    fp_wb_valid  = f; fp_wb_addr = fa; fp_wb_data = fd;
    trap_valid   = t; trap_cause = cause;
    @(posedge clock);
    if (acc) begin
      if (c) begin e = '{2'd0, 5'd0, pc, insn, exp_seq}; sb.push_back(e); exp_seq++; end
      if (i) begin e = '{2'd1, ia, id, 32'd0, exp_seq};  sb.push_back(e); exp_seq++; end
      if (f) begin e = '{2'd2, fa, fd, 32'd0, exp_seq};  sb.push_back(e); exp_seq++; end
      if (t) begin e = '{2'd3, 5'd0, cause, 32'd0, exp_seq}; sb.push_back(e); exp_seq++; end
    end
    #1;
    commit_valid = 0; int_wb_valid = 0; fp_wb_valid = 0; trap_valid = 0;
  endtask

  task automatic send_rand(input bit c, input bit i, input bit f, input bit t);
    send(c, i, f, t, {$urandom, $urandom}, $urandom, 5'($urandom), {$urandom, $urandom},
         5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic drain(input string nm);
    int k = 0;
    out_if.ready = 1;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clock); #1; k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain timeout: %0d records left, want 0", nm, sb.size());
    end
    @(posedge clock); #1;
    checks++;
    if (level !== 5'd0) begin
      errors++;
      $display("FAIL %s level after drain: got %0d want 0", nm, level);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({out_if.valid, level, overflow, drop_count, out_if.data, out_if.seq} !== '0) begin
      errors++;
      $display("FAIL reset state: v%b lvl%0d ovf%b drop%0d data%h seq%0d want all 0",
               out_if.valid, level, overflow, drop_count, out_if.data, out_if.seq);
    end
    @(posedge clock); #1;
    reset = 1;
  endtask

  task automatic test_single_commit();
    out_if.ready = 1;
    send(1, 0, 0, 0, 64'h80000000, 32'h00000013, 0, 0, 0, 0, 0);
    checks++;
    if ({out_if.valid, out_if.kind, out_if.data, out_if.insn, out_if.seq} !==
        {1'b1, 2'd0, 64'h80000000, 32'h13, 4'd0}) begin
      errors++;
      $display("FAIL single commit: got v%b k%0d d%h i%h s%0d want v1 k0 d80000000 i13 s0",
               out_if.valid, out_if.kind, out_if.data, out_if.insn, out_if.seq);
    end
    @(posedge clock); #1;
    checks++;
    if (level !== 5'd0) begin
      errors++;
      $display("FAIL single level: got %0d want 0", level);
    end
  endtask

  task automatic test_all_four();
    out_if.ready = 1;
    send(1, 1, 1, 1, 64'h80000004, 32'h00500293, 5'd5, 64'h1234,
         5'd3, 64'h3FF0000000000000, 64'h8000000000000007);
    checks++;
    if (level !== 5'd4) begin
      errors++;
      $display("FAIL all four level: got %0d want 4", level);
    end
    drain("all_four");
  endtask

  task automatic test_backpressure();
    logic [108:0] snap;
    out_if.ready = 0;
    send_rand(1, 1, 1, 0);
    snap = {out_if.kind, out_if.addr, out_if.data, out_if.insn, out_if.seq};
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++;
      if ({out_if.kind, out_if.addr, out_if.data, out_if.insn, out_if.seq} !== snap ||
          level !== 5'd3) begin
        errors++;
        $display("FAIL stall stable cyc %0d: got lvl%0d rec %h want lvl3 rec %h", k, level,
                 {out_if.kind, out_if.addr, out_if.data, out_if.insn, out_if.seq}, snap);
      end
    end
    @(posedge clock); #1;
    drain("backpressure");
  endtask

  task automatic test_overflow();
    out_if.ready = 0;
    repeat (3) send_rand(1, 1, 1, 1);
    send_rand(1, 0, 0, 1);
    checks++;
    if (level !== 5'd14) begin
      errors++;
      $display("FAIL fill level: got %0d want 14", level);
    end
    send_rand(1, 1, 1, 1);
    checks++;
    if ({level, overflow, drop_count} !== {5'd14, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL reject: got lvl%0d ovf%b drop%0d want lvl14 ovf1 drop1",
               level, overflow, drop_count);
    end
    send_rand(0, 1, 1, 0);
    checks++;
    if (level !== 5'd16) begin
      errors++;
      $display("FAIL accept to full: got %0d want 16", level);
    end
    clr_overflow = 1;
    @(posedge clock); #1;
    clr_overflow = 0;
    checks++;
    if ({overflow, drop_count} !== {1'b0, 16'd0}) begin
      errors++;
      $display("FAIL clear: got ovf%b drop%0d want ovf0 drop0", overflow, drop_count);
    end
    send_rand(0, 0, 1, 0);
    send_rand(0, 0, 1, 0);
    clr_overflow = 1;
    send_rand(1, 0, 0, 0);
    clr_overflow = 0;
    checks++;
    if ({overflow, drop_count} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL clear vs reject: got ovf%b drop%0d want ovf1 drop1", overflow, drop_count);
    end
    drain("overflow");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      out_if.ready = $urandom_range(0, 1);
      send_rand($urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1));
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_stream();
    out_if.ready = 0;
    send_rand(1, 1, 1, 1);
    send_rand(1, 0, 0, 0);
    checks++;
    if ({out_if.valid, level} !== {1'b1, 5'd5}) begin
      errors++;
      $display("FAIL pre-reset: got v%b lvl%0d want v1 lvl5", out_if.valid, level);
    end
    reset = 0;
    #1;
    checks++;
    if ({out_if.valid, out_if.data, level} !== '0) begin
      errors++;
      $display("FAIL async reset: got v%b d%h lvl%0d want 0", out_if.valid, out_if.data, level);
    end
    sb.delete();
    exp_seq = '0;
    @(posedge clock); #1;
    reset = 1;
    out_if.ready = 1;
    send(1, 0, 0, 0, 64'h80000100, 32'h00100073, 0, 0, 0, 0, 0);
    checks++;
    if ({out_if.valid, out_if.seq} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL post-reset seq: got v%b s%0d want v1 s0", out_if.valid, out_if.seq);
    end
    drain("reset_mid");
  endtask

  task automatic test_seq_wrap();
    out_if.ready = 1;
    for (int k = 0; k < 18; k++) send_rand(1, 0, 0, 0);
    checks++;
    if (exp_seq !== 4'd3) begin
      errors++;
      $display("FAIL seq model: got %0d want 3", exp_seq);
    end
    drain("seq_wrap");
  endtask

  initial begin
    reset = 0; clr_overflow = 0; out_if.ready = 0; exp_seq = '0;
    commit_valid = 0; int_wb_valid = 0; fp_wb_valid = 0; trap_valid = 0;
    commit_pc = 0; commit_insn = 0; int_wb_addr = 0; int_wb_data = 0;
    fp_wb_addr = 0; fp_wb_data = 0; trap_cause = 0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_single_commit();
    test_all_four();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid_stream();
    test_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
